// File: rtl/ethpipe_rx_slot_sched.sv
// ethpipe_rx_slot_sched: round-robin RX slot allocator for two ports, with an in-order ready FIFO toward the host.
// Define RX_SLOT_IRQ_EN to add the irq/irq_ack interrupt pair.
module ethpipe_rx_slot_sched #(
    parameter int NSLOT  = 4,
    parameter int SLOT_W = 2,
    parameter int LEN_W  = 12
) (
    input  logic              clk_125,
    input  logic              sys_rst_n,
    input  logic              p0_req,
    output logic              p0_gnt,
    output logic [SLOT_W-1:0] p0_slot,
    output logic              p0_busy,
    input  logic              p0_done,
    input  logic [LEN_W-1:0]  p0_len,
    input  logic              p1_req,
    output logic              p1_gnt,
    output logic [SLOT_W-1:0] p1_slot,
    output logic              p1_busy,
    input  logic              p1_done,
    input  logic [LEN_W-1:0]  p1_len,
    output logic              host_rdy,
    output logic [SLOT_W-1:0] host_slot,
    output logic              host_port,
    output logic [LEN_W-1:0]  host_len,
    input  logic              host_pop,
    input  logic              host_rel,
    input  logic [SLOT_W-1:0] host_rel_slot,
    output logic [SLOT_W:0]   free_cnt,
    output logic              err
`ifdef RX_SLOT_IRQ_EN
    ,
    output logic              irq,
    input  logic              irq_ack
`endif
);

    typedef enum logic [2:0] {
        ST_FREE,
        ST_FILL0,
        ST_FILL1,
        ST_READY,
        ST_HOST
    } slot_state_t;

    slot_state_t       slot_st   [NSLOT];
    logic [SLOT_W-1:0] fifo_slot [NSLOT];
    logic              fifo_port [NSLOT];
    logic [LEN_W-1:0]  fifo_len  [NSLOT];
    logic [SLOT_W-1:0] rd_ptr;
    logic [SLOT_W-1:0] wr_ptr;
    logic [SLOT_W:0]   fifo_cnt;
    logic              rr_sel;

    logic              free_any;
    logic [SLOT_W-1:0] free_idx;
    logic [SLOT_W:0]   n_free;
    logic              elig0;
    logic              elig1;
    logic              gnt0_nxt;
    logic              gnt1_nxt;
    logic              push0;
    logic              push1;
    logic              pop_ok;
    logic              rel_ok;
    logic              bad_req;
    logic [SLOT_W-1:0] wr_ptr_p1;
    logic [SLOT_W-1:0] wr_ptr_p2;
    logic [SLOT_W:0]   fifo_cnt_nxt;

    function automatic logic [SLOT_W-1:0] ptr_inc(input logic [SLOT_W-1:0] p);
        return (p == SLOT_W'(NSLOT - 1)) ? '0 : p + SLOT_W'(1);
    endfunction

    // Lowest-index free slot, free count and release legality all come from the current state vector.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        n_free   = '0;
        rel_ok   = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (slot_st[i] == ST_FREE) begin
                n_free = n_free + (SLOT_W+1)'(1);
                if (!free_any) begin
                    free_any = 1'b1;
                    free_idx = SLOT_W'(i);
                end
            end
            if (host_rel && (host_rel_slot == SLOT_W'(i)) && (slot_st[i] == ST_HOST))
                rel_ok = 1'b1;
        end
    end

    // rr_sel=1 means port1 wins a tie; a lone eligible port always wins.
    always_comb begin
        elig0        = p0_req && !p0_busy && free_any;
        elig1        = p1_req && !p1_busy && free_any;
        gnt0_nxt     = elig0 && (!elig1 || !rr_sel);
        gnt1_nxt     = elig1 && !gnt0_nxt;
        push0        = p0_done && p0_busy;
        push1        = p1_done && p1_busy;
        pop_ok       = host_pop && (fifo_cnt != '0);
        bad_req      = (p0_done && !p0_busy) || (p1_done && !p1_busy) ||
                       (host_pop && (fifo_cnt == '0)) || (host_rel && !rel_ok);
        wr_ptr_p1    = ptr_inc(wr_ptr);
        wr_ptr_p2    = ptr_inc(wr_ptr_p1);
        fifo_cnt_nxt = fifo_cnt + (SLOT_W+1)'(push0) + (SLOT_W+1)'(push1) - (SLOT_W+1)'(pop_ok);
    end

    // Grant, done, pop and release each touch a slot in a distinct state, so their writes never collide.
    always_ff @(posedge clk_125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                slot_st[i]   <= ST_FREE;
                fifo_slot[i] <= '0;
                fifo_port[i] <= 1'b0;
                fifo_len[i]  <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            rr_sel   <= 1'b0;
            p0_gnt   <= 1'b0;
            p1_gnt   <= 1'b0;
            p0_busy  <= 1'b0;
            p1_busy  <= 1'b0;
            p0_slot  <= '0;
            p1_slot  <= '0;
            err      <= 1'b0;
        end else begin
            p0_gnt <= gnt0_nxt;
            p1_gnt <= gnt1_nxt;
            if (gnt0_nxt) begin
                p0_busy           <= 1'b1;
                p0_slot           <= free_idx;
                slot_st[free_idx] <= ST_FILL0;
                rr_sel            <= 1'b1;
            end else if (gnt1_nxt) begin
                p1_busy           <= 1'b1;
                p1_slot           <= free_idx;
                slot_st[free_idx] <= ST_FILL1;
                rr_sel            <= 1'b0;
            end
            if (push0) begin
                slot_st[p0_slot]  <= ST_READY;
                p0_busy           <= 1'b0;
                fifo_slot[wr_ptr] <= p0_slot;
                fifo_port[wr_ptr] <= 1'b0;
                fifo_len[wr_ptr]  <= p0_len;
            end
            if (push1) begin
                slot_st[p1_slot] <= ST_READY;
                p1_busy          <= 1'b0;
                fifo_slot[push0 ? wr_ptr_p1 : wr_ptr] <= p1_slot;
                fifo_port[push0 ? wr_ptr_p1 : wr_ptr] <= 1'b1;
                fifo_len[push0 ? wr_ptr_p1 : wr_ptr]  <= p1_len;
            end
            if (push0 && push1)
                wr_ptr <= wr_ptr_p2;
            else if (push0 || push1)
                wr_ptr <= wr_ptr_p1;
            if (pop_ok) begin
                slot_st[fifo_slot[rd_ptr]] <= ST_HOST;
                rd_ptr                     <= ptr_inc(rd_ptr);
            end
            if (rel_ok)
                slot_st[host_rel_slot] <= ST_FREE;
            fifo_cnt <= fifo_cnt_nxt;
            if (bad_req)
                err <= 1'b1;
        end
    end

    assign host_rdy  = (fifo_cnt != '0);
    assign host_slot = host_rdy ? fifo_slot[rd_ptr] : '0;
    assign host_port = host_rdy ? fifo_port[rd_ptr] : 1'b0;
    assign host_len  = host_rdy ? fifo_len[rd_ptr]  : '0;
    assign free_cnt  = n_free;

`ifdef RX_SLOT_IRQ_EN
    // A push in the same cycle as the acknowledge keeps the interrupt asserted.
    always_ff @(posedge clk_125 or negedge sys_rst_n) begin
        if (!sys_rst_n)
            irq <= 1'b0;
        else if (push0 || push1)
            irq <= 1'b1;
        else if (irq_ack)
            irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_ethpipe_rx_slot_sched.sv
// Testbench for ethpipe_rx_slot_sched: directed scenarios plus randomized traffic against a queue-based model.
module tb_ethpipe_rx_slot_sched;

    localparam int NSLOT  = 4;
    localparam int SLOT_W = 2;
    localparam int LEN_W  = 12;
    localparam int S_FREE = 0, S_FILL0 = 1, S_FILL1 = 2, S_READY = 3, S_HOST = 4;

    logic              clk_125 = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              p0_req = 0, p0_done = 0, p1_req = 0, p1_done = 0;
    logic [LEN_W-1:0]  p0_len = '0, p1_len = '0;
    logic              host_pop = 0, host_rel = 0;
    logic [SLOT_W-1:0] host_rel_slot = '0;
    logic              p0_gnt, p0_busy, p1_gnt, p1_busy;
    logic [SLOT_W-1:0] p0_slot, p1_slot, host_slot;
    logic              host_rdy, host_port, err;
    logic [LEN_W-1:0]  host_len;
    logic [SLOT_W:0]   free_cnt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int slot;
        int port;
        int len;
    } ent_t;

    int   m_st   [NSLOT];
    bit   m_busy [2];
    int   m_slot [2];
    bit   m_gnt  [2];
    int   m_last;
    bit   m_err;
    ent_t m_q    [$];

    ethpipe_rx_slot_sched #(.NSLOT(NSLOT), .SLOT_W(SLOT_W), .LEN_W(LEN_W)) dut (
        .clk_125(clk_125), .sys_rst_n(sys_rst_n),
        .p0_req(p0_req), .p0_gnt(p0_gnt), .p0_slot(p0_slot), .p0_busy(p0_busy),
        .p0_done(p0_done), .p0_len(p0_len),
        .p1_req(p1_req), .p1_gnt(p1_gnt), .p1_slot(p1_slot), .p1_busy(p1_busy),
        .p1_done(p1_done), .p1_len(p1_len),
        .host_rdy(host_rdy), .host_slot(host_slot), .host_port(host_port), .host_len(host_len),
        .host_pop(host_pop), .host_rel(host_rel), .host_rel_slot(host_rel_slot),
        .free_cnt(free_cnt), .err(err)
    );

    always #4 clk_125 = ~clk_125;

    task automatic model_reset();
        for (int i = 0; i < NSLOT; i++) m_st[i] = S_FREE;
        m_busy[0] = 0; m_busy[1] = 0; m_slot[0] = 0; m_slot[1] = 0;
        m_gnt[0] = 0;  m_gnt[1] = 0;
        m_last = 1;
        m_err  = 0;
        m_q.delete();
    endtask

    function automatic int model_free();
        int n = 0;
        for (int i = 0; i < NSLOT; i++) if (m_st[i] == S_FREE) n++;
        return n;
    endfunction

    // Evaluates one clock edge from the spec rules, reading every condition from the pre-edge state.
    task automatic model_step();
        int   pre [NSLOT];
        int   low, win, qn;
        bit   e0, e1;
        ent_t e;
        pre = m_st;
        low = -1;
        for (int i = 0; i < NSLOT; i++) if (pre[i] == S_FREE && low < 0) low = i;
        e0  = p0_req && !m_busy[0] && (low >= 0);
        e1  = p1_req && !m_busy[1] && (low >= 0);
        win = -1;
        if (e0 && e1) win = (m_last == 1) ? 0 : 1;
        else if (e0)  win = 0;
        else if (e1)  win = 1;
        m_gnt[0] = (win == 0);
        m_gnt[1] = (win == 1);
        qn = m_q.size();
        if (p0_done) begin
            if (m_busy[0]) begin
                m_st[m_slot[0]] = S_READY;
                e.slot = m_slot[0]; e.port = 0; e.len = int'(p0_len);
                m_q.push_back(e);
                m_busy[0] = 0;
            end else m_err = 1;
        end
        if (p1_done) begin
            if (m_busy[1]) begin
                m_st[m_slot[1]] = S_READY;
                e.slot = m_slot[1]; e.port = 1; e.len = int'(p1_len);
                m_q.push_back(e);
                m_busy[1] = 0;
            end else m_err = 1;
        end
        if (host_pop) begin
            if (qn > 0) begin
                m_st[m_q[0].slot] = S_HOST;
                void'(m_q.pop_front());
            end else m_err = 1;
        end
        if (host_rel) begin
            if (pre[int'(host_rel_slot)] == S_HOST) m_st[int'(host_rel_slot)] = S_FREE;
            else m_err = 1;
        end
        if (win >= 0) begin
            m_st[low]   = (win == 0) ? S_FILL0 : S_FILL1;
            m_busy[win] = 1;
            m_slot[win] = low;
            m_last      = win;
        end
    endtask

    task automatic tick();
        if (sys_rst_n) model_step();
        @(posedge clk_125);
        #1;
    endtask

    task automatic clear_inputs();
        p0_req = 0; p0_done = 0; p0_len = '0;
        p1_req = 0; p1_done = 0; p1_len = '0;
        host_pop = 0; host_rel = 0; host_rel_slot = '0;
    endtask

    task automatic do_reset();
        sys_rst_n = 0;
        clear_inputs();
        model_reset();
        @(negedge clk_125);
        @(negedge clk_125);
        sys_rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (free_cnt !== 3'd4) begin n_err++; $display("[TB] FAIL rst_free got %0d want 4", free_cnt); end
        n_vec++; if (host_rdy !== 1'b0) begin n_err++; $display("[TB] FAIL rst_rdy got %b want 0", host_rdy); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("[TB] FAIL rst_err got %b want 0", err); end
        n_vec++; if ({p0_gnt, p1_gnt, p0_busy, p1_busy} !== 4'b0) begin n_err++; $display("[TB] FAIL rst_gnt_busy got %b want 0000", {p0_gnt, p1_gnt, p0_busy, p1_busy}); end
        n_vec++; if ({host_slot, host_port, host_len} !== '0) begin n_err++; $display("[TB] FAIL rst_head got %0d/%0d/%0d want 0/0/0", host_slot, host_port, host_len); end
        p0_req = 1;
        tick();
        p0_req = 0;
        n_vec++; if (p0_gnt !== 1'b1) begin n_err++; $display("[TB] FAIL first_gnt got %b want 1", p0_gnt); end
        n_vec++; if (p0_slot !== 2'd0 || p0_busy !== 1'b1) begin n_err++; $display("[TB] FAIL first_slot got %0d busy %b want 0 busy 1", p0_slot, p0_busy); end
        n_vec++; if (free_cnt !== 3'd3) begin n_err++; $display("[TB] FAIL first_free got %0d want 3", free_cnt); end
        tick();
        n_vec++; if (p0_gnt !== 1'b0) begin n_err++; $display("[TB] FAIL gnt_pulse got %b want 0", p0_gnt); end
    endtask

    task automatic test_round_robin();
        do_reset();
        p0_req = 1; p1_req = 1;
        tick();
        n_vec++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || p0_slot !== 2'd0) begin n_err++; $display("[TB] FAIL rr_first got g0=%b g1=%b s=%0d want 1 0 0", p0_gnt, p1_gnt, p0_slot); end
        tick();
        p0_req = 0; p1_req = 0;
        n_vec++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || p1_slot !== 2'd1) begin n_err++; $display("[TB] FAIL rr_second got g0=%b g1=%b s=%0d want 0 1 1", p0_gnt, p1_gnt, p1_slot); end
        n_vec++; if (free_cnt !== 3'd2) begin n_err++; $display("[TB] FAIL rr_free got %0d want 2", free_cnt); end
    endtask

    task automatic test_fifo_order();
        p1_done = 1; p1_len = 12'd64;
        tick();
        p1_done = 0;
        n_vec++; if (host_rdy !== 1'b1 || host_slot !== 2'd1 || host_port !== 1'b1 || host_len !== 12'd64) begin n_err++; $display("[TB] FAIL fifo_head1 got %b %0d/%0d/%0d want 1 1/1/64", host_rdy, host_slot, host_port, host_len); end
        p0_done = 1; p0_len = 12'd1514;
        tick();
        p0_done = 0;
        n_vec++; if (host_slot !== 2'd1 || host_len !== 12'd64) begin n_err++; $display("[TB] FAIL fifo_hold got %0d/%0d want 1/64", host_slot, host_len); end
        host_pop = 1;
        tick();
        host_pop = 0;
        n_vec++; if (host_rdy !== 1'b1 || host_slot !== 2'd0 || host_port !== 1'b0 || host_len !== 12'd1514) begin n_err++; $display("[TB] FAIL fifo_head2 got %b %0d/%0d/%0d want 1 0/0/1514", host_rdy, host_slot, host_port, host_len); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("[TB] FAIL fifo_err got %b want 0", err); end
    endtask

    task automatic test_full_release();
        do_reset();
        p0_req = 1; p1_req = 1;
        tick(); tick();
        p0_done = 1; p0_len = 12'd100; p1_done = 1; p1_len = 12'd200;
        tick();
        p0_done = 0; p1_done = 0;
        n_vec++; if (host_slot !== 2'd0 || host_port !== 1'b0 || host_len !== 12'd100) begin n_err++; $display("[TB] FAIL dual_done_head got %0d/%0d/%0d want 0/0/100", host_slot, host_port, host_len); end
        tick();
        n_vec++; if (p0_gnt !== 1'b1 || p0_slot !== 2'd2) begin n_err++; $display("[TB] FAIL regrant0 got g=%b s=%0d want 1 2", p0_gnt, p0_slot); end
        tick();
        n_vec++; if (p1_gnt !== 1'b1 || p1_slot !== 2'd3) begin n_err++; $display("[TB] FAIL regrant1 got g=%b s=%0d want 1 3", p1_gnt, p1_slot); end
        p0_done = 1; p0_len = 12'd300; p1_done = 1; p1_len = 12'd400;
        tick();
        p0_done = 0; p1_done = 0;
        tick();
        n_vec++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || free_cnt !== 3'd0) begin n_err++; $display("[TB] FAIL pool_empty got g=%b%b free=%0d want 00 0", p0_gnt, p1_gnt, free_cnt); end
        p1_req = 0;
        host_pop = 1;
        tick();
        n_vec++; if (host_slot !== 2'd1 || host_port !== 1'b1 || host_len !== 12'd200) begin n_err++; $display("[TB] FAIL dual_done_second got %0d/%0d/%0d want 1/1/200", host_slot, host_port, host_len); end
        tick(); tick();
        host_pop = 0;
        n_vec++; if (host_slot !== 2'd3 || host_len !== 12'd400) begin n_err++; $display("[TB] FAIL pop3_head got %0d/%0d want 3/400", host_slot, host_len); end
        host_rel = 1; host_rel_slot = 2'd2;
        tick();
        host_rel = 0;
        n_vec++; if (p0_gnt !== 1'b0 || free_cnt !== 3'd1) begin n_err++; $display("[TB] FAIL rel_same_cycle got g=%b free=%0d want 0 1", p0_gnt, free_cnt); end
        tick();
        p0_req = 0;
        n_vec++; if (p0_gnt !== 1'b1 || p0_slot !== 2'd2 || free_cnt !== 3'd0) begin n_err++; $display("[TB] FAIL rel_regrant got g=%b s=%0d free=%0d want 1 2 0", p0_gnt, p0_slot, free_cnt); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("[TB] FAIL full_err got %b want 0", err); end
    endtask

    task automatic test_errors();
        do_reset();
        p0_req = 1;
        tick();
        p0_req = 0;
        host_rel = 1; host_rel_slot = 2'd1;
        tick();
        host_rel = 0;
        n_vec++; if (err !== 1'b1 || free_cnt !== 3'd3 || host_rdy !== 1'b0) begin n_err++; $display("[TB] FAIL err_rel_free got err=%b free=%0d rdy=%b want 1 3 0", err, free_cnt, host_rdy); end
        do_reset();
        p1_done = 1; p1_len = 12'd77;
        tick();
        p1_done = 0;
        n_vec++; if (err !== 1'b1 || free_cnt !== 3'd4 || host_rdy !== 1'b0 || p1_busy !== 1'b0) begin n_err++; $display("[TB] FAIL err_done_idle got err=%b free=%0d rdy=%b busy=%b want 1 4 0 0", err, free_cnt, host_rdy, p1_busy); end
        do_reset();
        host_pop = 1;
        tick();
        host_pop = 0;
        n_vec++; if (err !== 1'b1 || free_cnt !== 3'd4 || host_rdy !== 1'b0) begin n_err++; $display("[TB] FAIL err_pop_empty got err=%b free=%0d rdy=%b want 1 4 0", err, free_cnt, host_rdy); end
        tick();
        n_vec++; if (err !== 1'b1) begin n_err++; $display("[TB] FAIL err_sticky got %b want 1", err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        p0_req = 1; p1_req = 1;
        tick(); tick();
        p0_req = 0; p1_req = 0;
        p0_done = 1; p1_done = 1;
        tick();
        p0_done = 0; p1_done = 0;
        p0_req = 1;
        tick();
        p0_req = 0;
        n_vec++; if (p0_busy !== 1'b1 || free_cnt !== 3'd1 || host_rdy !== 1'b1) begin n_err++; $display("[TB] FAIL mid_setup got busy=%b free=%0d rdy=%b want 1 1 1", p0_busy, free_cnt, host_rdy); end
        sys_rst_n = 0;
        #1;
        n_vec++; if (host_rdy !== 1'b0 || p0_busy !== 1'b0 || free_cnt !== 3'd4) begin n_err++; $display("[TB] FAIL mid_reset got rdy=%b busy=%b free=%0d want 0 0 4", host_rdy, p0_busy, free_cnt); end
        do_reset();
    endtask

    task automatic test_random();
        int s;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            p0_req  = 1'($urandom_range(0, 1));
            p1_req  = 1'($urandom_range(0, 1));
            p0_done = (m_busy[0] && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0);
            p1_done = (m_busy[1] && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0);
            p0_len  = LEN_W'($urandom);
            p1_len  = LEN_W'($urandom);
            host_pop = (m_q.size() > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 199) == 0);
            s = $urandom_range(0, NSLOT - 1);
            host_rel_slot = SLOT_W'(s);
            host_rel = (m_st[s] == S_HOST && $urandom_range(0, 1) == 0) || ($urandom_range(0, 199) == 0);
            tick();
            n_vec++; if (p0_gnt !== m_gnt[0] || p1_gnt !== m_gnt[1]) begin n_err++; $display("[TB] FAIL rnd_gnt c=%0d got %b%b want %b%b", c, p0_gnt, p1_gnt, m_gnt[0], m_gnt[1]); end
            n_vec++; if (p0_busy !== m_busy[0] || p1_busy !== m_busy[1]) begin n_err++; $display("[TB] FAIL rnd_busy c=%0d got %b%b want %b%b", c, p0_busy, p1_busy, m_busy[0], m_busy[1]); end
            if (m_busy[0]) begin
                n_vec++; if (int'(p0_slot) != m_slot[0]) begin n_err++; $display("[TB] FAIL rnd_slot0 c=%0d got %0d want %0d", c, p0_slot, m_slot[0]); end
            end
            if (m_busy[1]) begin
                n_vec++; if (int'(p1_slot) != m_slot[1]) begin n_err++; $display("[TB] FAIL rnd_slot1 c=%0d got %0d want %0d", c, p1_slot, m_slot[1]); end
            end
            n_vec++; if (host_rdy !== (m_q.size() > 0)) begin n_err++; $display("[TB] FAIL rnd_rdy c=%0d got %b want %0d", c, host_rdy, m_q.size() > 0); end
            if (m_q.size() > 0) begin
                n_vec++; if (int'(host_slot) != m_q[0].slot || int'(host_port) != m_q[0].port || int'(host_len) != m_q[0].len) begin n_err++; $display("[TB] FAIL rnd_head c=%0d got %0d/%0d/%0d want %0d/%0d/%0d", c, host_slot, host_port, host_len, m_q[0].slot, m_q[0].port, m_q[0].len); end
            end
            n_vec++; if (int'(free_cnt) != model_free()) begin n_err++; $display("[TB] FAIL rnd_free c=%0d got %0d want %0d", c, free_cnt, model_free()); end
            n_vec++; if (err !== m_err) begin n_err++; $display("[TB] FAIL rnd_err c=%0d got %b want %b", c, err, m_err); end
            if (c % 500 == 499) do_reset();
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_fifo_order();
        test_full_release();
        test_errors();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
